// File: rtl/submaster_wr_arb_n.sv
// submaster_wr_arb_n: write-bus arbiter for NUM_SUBMASTERS requesters.
//   In IDLE it picks one requester from start and registers it as owner_id.
//   It then gives that owner a one-cycle grant pulse (GRANT).
//   It then holds ownership (WAIT) until the owner's xfer_done, or until the
//   optional watchdog expires.
// Arbitration: ARB_MODE 0 = fixed priority (index 0 highest),
//              ARB_MODE 1 = round robin, searching upward from rr_ptr.
// Optional watchdog: compiled in when SUBMASTER_WR_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk            - rising-edge clock
//   reset          - synchronous, active-high reset
//   start          - per-sub-master write request (level)
//   xfer_done      - per-sub-master transfer complete
//   timeout_cycles - watchdog limit in WAIT cycles, 0 disables it
//   grant          - one-hot single-cycle grant pulse
//   processing     - one-hot owner indication during GRANT and WAIT
//   owner_id       - index of the current or last owner
//   busy           - FSM not in IDLE
//   timeout_err    - single-cycle pulse on watchdog expiry
module submaster_wr_arb_n #(
  parameter int unsigned NUM_SUBMASTERS = 8,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned TIMEOUT_W      = 16,
  localparam int unsigned IDW = (NUM_SUBMASTERS > 2) ? $clog2(NUM_SUBMASTERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SUBMASTERS-1:0] start,
  input  logic [NUM_SUBMASTERS-1:0] xfer_done,
  input  logic [TIMEOUT_W-1:0]      timeout_cycles,
  output logic [NUM_SUBMASTERS-1:0] grant,
  output logic [NUM_SUBMASTERS-1:0] processing,
  output logic [IDW-1:0]            owner_id,
  output logic                      busy,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_next;
  logic [IDW-1:0] winner;
  logic           found;
  logic           done;
  logic           expire;
  logic           xfer_end;

  // Scan all requesters starting at rr_ptr (round robin) or 0 (fixed);
  // the first set request found wins.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_SUBMASTERS; i++) begin
      idx = (ARB_MODE == 1) ? 32'(rr_ptr) + i : i;
      if (idx >= NUM_SUBMASTERS) idx = idx - NUM_SUBMASTERS;
      if (!found && start[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign done     = xfer_done[owner_id];
  assign xfer_end = (state == WAIT) && (done || expire);
  assign rr_next  = (owner_id == IDW'(NUM_SUBMASTERS - 1)) ? '0 : owner_id + IDW'(1);

`ifdef SUBMASTER_WR_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [TIMEOUT_W-1:0] wd_cnt_inc;

  // wd_cnt_inc is the count including the current WAIT cycle, so the
  // pulse lands on WAIT cycle number timeout_cycles.
  assign wd_cnt_inc = (&wd_cnt) ? wd_cnt : wd_cnt + TIMEOUT_W'(1);
  assign expire     = (state == WAIT) && (timeout_cycles != '0) &&
                      (wd_cnt_inc == timeout_cycles) && !done;

  always_ff @(posedge clk) begin
    if (reset)               wd_cnt <= '0;
    else if (state == GRANT) wd_cnt <= '0;
    else if (state == WAIT)  wd_cnt <= wd_cnt_inc;
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^timeout_cycles;
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && found) owner_id <= winner;
      if (xfer_end)               rr_ptr   <= rr_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (found) state_next = GRANT;
      GRANT:   state_next = WAIT;
      WAIT:    if (done || expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, not only after the edge.
  always_comb begin
    grant      = '0;
    processing = '0;
    if (!reset && state != IDLE)  processing[owner_id] = 1'b1;
    if (!reset && state == GRANT) grant[owner_id]      = 1'b1;
  end

  assign busy        = !reset && (state != IDLE);
  assign timeout_err = !reset && expire;

endmodule

// File: tb/tb_submaster_wr_arb_n.sv
// Testbench for submaster_wr_arb_n: one fixed-priority instance and one
// round-robin instance, both with 8 sub-masters.
// Transactions are generated at random and from a few fixed scenarios. For
// every cycle, the driver pushes the expected outputs into a per-instance
// queue. A monitor pops each entry at the falling edge and compares it with
// the DUT outputs.
module tb_submaster_wr_arb_n;
  localparam int N = 8;
`ifdef SUBMASTER_WR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  start0 = '0, start1 = '0, xd0 = '0, xd1 = '0;
  logic [15:0] tcyc = '0;
  logic [7:0]  grant0, grant1, proc0, proc1;
  logic [2:0]  own0, own1;
  logic        busy0, busy1, terr0, terr1;

  always #5 clk = ~clk;

  submaster_wr_arb_n #(.NUM_SUBMASTERS(8), .ARB_MODE(0), .TIMEOUT_W(16)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .xfer_done(xd0),
    .timeout_cycles(tcyc), .grant(grant0), .processing(proc0),
    .owner_id(own0), .busy(busy0), .timeout_err(terr0));

  submaster_wr_arb_n #(.NUM_SUBMASTERS(8), .ARB_MODE(1), .TIMEOUT_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .xfer_done(xd1),
    .timeout_cycles(tcyc), .grant(grant1), .processing(proc1),
    .owner_id(own1), .busy(busy1), .timeout_err(terr1));

  typedef struct packed {
    logic       busy;
    logic [7:0] grant;
    logic [7:0] proc;
    logic [2:0] owner;
    logic       terr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  int   last_owner[2] = '{0, 0};
  int   ptr[2] = '{0, 0};

  function automatic exp_t mk(input logic b, input logic [7:0] g, input logic [7:0] p,
                              input logic [2:0] o, input logic t);
    exp_t e;
    e.busy = b; e.grant = g; e.proc = p; e.owner = o; e.terr = t;
    return e;
  endfunction

  // Reference arbitration: first requester found scanning from 0
  // (fixed priority) or from the round-robin pointer with wrap-around.
  function automatic int pick(input logic [7:0] s, input int m, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m == 0) ? k : (p + k) % N;
      if (s[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [7:0] rnd_s();
    logic [7:0] v;
    v = 8'($urandom);
    if ($urandom_range(0, 4) == 0) v = '0;
    return v;
  endfunction

  task automatic cmp(input string name, input int m, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, m, $time, act, req);
    end
  endtask

  task automatic cmp_rec(input int m, input exp_t e, input logic b, input logic [7:0] g,
                         input logic [7:0] p, input logic [2:0] o, input logic t);
    cmp("busy", m, {7'd0, b}, {7'd0, e.busy});
    cmp("grant", m, g, e.grant);
    cmp("processing", m, p, e.proc);
    cmp("owner_id", m, {5'd0, o}, {5'd0, e.owner});
    cmp("timeout_err", m, {7'd0, t}, {7'd0, e.terr});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      cmp_rec(0, e, busy0, grant0, proc0, own0, terr0);
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      cmp_rec(1, e, busy1, grant1, proc1, own1, terr1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int m, input exp_t e);
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(input int m, input logic [7:0] s, input logic [7:0] x);
    if (m == 0) begin start0 = s; xd0 = x; end
    else        begin start1 = s; xd1 = x; end
  endtask

  // Called in the current cycle: assert reset for one edge, then release it.
  task automatic reset_cycle();
    reset = 1'b1;
    drive(0, '0, '0);
    drive(1, '0, '0);
    push(0, mk(1'b0, '0, '0, 3'(last_owner[0]), 1'b0));
    push(1, mk(1'b0, '0, '0, 3'(last_owner[1]), 1'b0));
    tick();
    reset = 1'b0;
    push(0, mk(1'b0, '0, '0, 3'd0, 1'b0));
    push(1, mk(1'b0, '0, '0, 3'd0, 1'b0));
    last_owner = '{0, 0};
    ptr = '{0, 0};
  endtask

  // One ownership on instance m. In the idle cycle, start=s is driven.
  // The owner then completes on WAIT cycle wait_len+1, unless the watchdog
  // (limit tc) expires first or reset is asserted on WAIT cycle abort_at.
  task automatic run_txn(input int m, input logic [7:0] s, input int wait_len,
                         input int tc, input logic [7:0] noise, input int abort_at);
    int         w;
    logic [7:0] oh;
    logic [7:0] x;
    logic       fin;
    logic       terr;
    tick();
    tcyc = 16'(tc);
    drive(1 - m, '0, '0);
    drive(m, s, noise);
    push(m, mk(1'b0, '0, '0, 3'(last_owner[m]), 1'b0));
    push(1 - m, mk(1'b0, '0, '0, 3'(last_owner[1 - m]), 1'b0));
    if (s == '0) return;
    w  = pick(s, m, ptr[m]);
    oh = 8'(1) << w;
    last_owner[m] = w;
    tick();
    drive(m, 8'($urandom), noise | oh);
    push(m, mk(1'b1, oh, oh, 3'(w), 1'b0));
    for (int c = 1; c <= wait_len + 1; c++) begin
      tick();
      if (c == abort_at) begin
        reset_cycle();
        return;
      end
      fin  = (c == wait_len + 1);
      x    = fin ? (noise | oh) : (noise & ~oh);
      drive(m, 8'($urandom), x);
      terr = TO_EN && (tc != 0) && (c == tc) && !fin;
      push(m, mk(1'b1, '0, oh, 3'(w), terr));
      if (terr) break;
    end
    ptr[m] = (w + 1) % N;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    tick();
    reset_cycle();
    // Fixed priority picks index 2 out of 1010_0100.
    run_txn(0, 8'b1010_0100, 3, 0, 8'h00, 0);
    // Owner 3 with every other xfer_done bit set.
    run_txn(0, 8'hF8, 2, 0, 8'b1111_0111, 0);
    repeat (60) run_txn(0, rnd_s(), $urandom_range(0, 6), $urandom_range(0, 6), 8'($urandom), 0);
    // Round robin with all requesting: 0,1,...,7,0.
    repeat (9) run_txn(1, 8'hFF, 1, 0, 8'($urandom), 0);
    repeat (60) run_txn(1, rnd_s(), $urandom_range(0, 6), $urandom_range(0, 6), 8'($urandom), 0);
    // Reset during WAIT with owner 6, then round robin restarts at 0.
    run_txn(1, 8'h40, 5, 0, 8'h00, 3);
    run_txn(1, 8'hFF, 1, 0, 8'h00, 0);
    // Watchdog limit 5, then a disabled watchdog across a 1000-cycle WAIT.
    run_txn(0, 8'h01, 20, 5, 8'h00, 0);
    run_txn(0, 8'h02, 1000, 0, 8'h00, 0);
    tick();
    drive(0, '0, '0);
    drive(1, '0, '0);
    @(negedge clk);
    #1;
    cmp("queue_drain0", 0, 8'(q0.size()), 8'd0);
    cmp("queue_drain1", 1, 8'(q1.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
